bcd_tens_display: RTL
=====================

Name: bcd_tens_display

Overview:
- Downstream stage of the mod-10 up/down ones counter.
- Consumes its digit `q`, wrap flag `c` and direction `d`, and keeps the cascaded tens digit.
- Drives a two-digit, time-multiplexed 7-segment display with anti-ghosting blank slots.
- Output feeds the board-level segment and anode pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit per scan slot (>=2)
- BLANK_CYCLES, 100, cycles all anodes are off between digits (>=1)
- SEG_ACTIVE_LOW, 1, 1 = segments and anodes driven active-low; 0 = active-high

Ports:
- clk    in   1  system clock, all logic on rising edge
- reset  in   1  synchronous, active-high reset
- d      in   1  count direction from the ones stage: 0 = up, 1 = down
- q      in   4  ones digit, BCD 0..9
- c      in   1  ones-stage wrap flag, level signal, may stay high several cycles
- tens   out  4  registered tens digit, BCD 0..9
- ovf    out  1  one-cycle pulse when tens wraps (9->0 up, 0->9 down)
- seg    out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- an     out  2  digit enables: an[0] = ones, an[1] = tens, polarity per SEG_ACTIVE_LOW

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on port `reset`. All registers update only on the rising edge of `clk`.
- Reset values:
  - tens = 0, ovf = 0, c_prev = 1.
  - Scan FSM = ONES, slot counter = 0.
  - seg and an are at inactive levels on the cycle reset is sampled; the ONES slot starts on the next cycle.
  - c_prev resets to 1 so a `c` held high through and out of reset is never counted.
- Carry detect: `c_rise = c & ~c_prev`; c_prev <= c every cycle. Only the rising edge counts; a `c` held high for N cycles counts once.
- Tens update, on the clock edge where c_rise = 1, with new tens visible the next cycle (1-cycle latency):
  - d = 0: tens = 9 -> 0 with ovf = 1, else tens + 1.
  - d = 1: tens = 0 -> 9 with ovf = 1, else tens - 1.
  - `d` is sampled on the same edge as c_rise.
- ovf is 1 for exactly that one cycle and is 0 otherwise.
- Width: tens arithmetic is 4-bit. A tens value outside 0..9 is unreachable; if forced, up goes to 0 and down goes to 9, with ovf = 0.
- Scan FSM states: ONES -> BLANK1 -> TENS -> BLANK0 -> ONES.
  - ONES and TENS last REFRESH_DIV cycles each; BLANK1 and BLANK0 last BLANK_CYCLES each.
  - The slot counter clears on every state change.
- Outputs per state, registered (1-cycle latency from state/digit to pins):
  - ONES: an[0] active, seg = decode(q).
  - TENS: an[1] active, seg = decode(tens).
  - BLANK1 / BLANK0: both an inactive, seg all-off.
- Decode: standard 0..9 patterns (1 = lit before the polarity step). q >= 10 displays the dash pattern (segment g only). The digit is resampled every cycle during a lit slot.
- Simultaneous events: a carry during any scan state updates tens independently. The TENS slot shows the new value from the cycle after the update, with no scan disturbance.
- Reset mid-operation: reset overrides everything on that edge, including a coincident c_rise, which is dropped.

Decomposition:
- Package bcd_disp_pkg holds:
  - scan state encoding constants ONES, BLANK1, TENS, BLANK0 (2-bit);
  - the 7-bit segment constants for digits 0..9, DASH and OFF.
- Sub-module bcd_to_7seg: pure combinational 4-bit to 7-bit, active-high output. The top applies the SEG_ACTIVE_LOW inversion.

Test Plan (REFRESH_DIV = 4, BLANK_CYCLES = 1, SEG_ACTIVE_LOW = 1):
1. Hold reset 2 cycles with c = 1, then release with c held high 5 cycles -> tens stays 0, ovf never 1. First lit slot: an = 2'b10, seg = 7'b1000000 for q = 0.
2. d = 0, tens = 9, pulse c high for 3 cycles -> next cycle tens = 0 with ovf = 1 for exactly 1 cycle; no further change while c stays high.
3. d = 1, tens = 0, one c rise -> tens = 9, ovf pulse. Second c rise -> tens = 8, ovf = 0.
4. Free-run 20 cycles with q = 3, tens = 7 -> repeating an pattern 10,10,10,10,11,01,01,01,01,11 (4 + 1 + 4 + 1). seg = 7'b0110000 during ones, 7'b1111000 during tens, 7'b1111111 during blanks.
5. q = 4'hC during a ONES slot -> seg = 7'b0111111 (dash).
6. Reset asserted in the same cycle as a c rise while tens = 5 -> tens = 0 after the edge, ovf = 0, FSM back in ONES.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared scan-state type and active-high 7-segment patterns {g,f,e,d,c,b,a}
// for the two-digit BCD display.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ONES   = 2'd0,
        BLANK1 = 2'd1,
        TENS   = 2'd2,
        BLANK0 = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high; non-BCD codes show a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_tens_display.sv
// Tens stage cascaded from a mod-10 up/down ones counter, driving a two-digit
// multiplexed 7-segment display with blank slots between digits.
module bcd_tens_display
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 100,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic [3:0] q,
    input  logic       c,
    output logic [3:0] tens,
    output logic       ovf,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned SLOT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CW       = (SLOT_MAX > 2) ? $clog2(SLOT_MAX) : 1;
    localparam logic [CW-1:0] LIT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_MASK  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    // ---------------- tens counter ----------------
    logic c_prev;
    logic c_rise;

    assign c_rise = c & ~c_prev;

    // Codes above 9 cannot arise from reset; they recover to 0 (up) or 9 (down) silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            tens   <= '0;
            ovf    <= 1'b0;
            c_prev <= 1'b1;
        end else begin
            c_prev <= c;
            ovf    <= 1'b0;
            if (c_rise) begin
                if (!d) begin
                    if (tens == 4'd9) begin
                        tens <= '0;
                        ovf  <= 1'b1;
                    end else if (tens > 4'd9) begin
                        tens <= '0;
                    end else begin
                        tens <= tens + 4'd1;
                    end
                end else begin
                    if (tens == 4'd0) begin
                        tens <= 4'd9;
                        ovf  <= 1'b1;
                    end else if (tens > 4'd9) begin
                        tens <= 4'd9;
                    end else begin
                        tens <= tens - 4'd1;
                    end
                end
            end
        end
    end

    // ---------------- scan FSM ----------------
    scan_state_t    state;
    scan_state_t    next_state;
    logic [CW-1:0]  cnt;
    logic           slot_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ONES;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= slot_last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        slot_last  = 1'b0;
        case (state)
            ONES: begin
                slot_last = (cnt == LIT_LAST);
                if (slot_last) next_state = BLANK1;
            end
            BLANK1: begin
                slot_last = (cnt == BLANK_LAST);
                if (slot_last) next_state = TENS;
            end
            TENS: begin
                slot_last = (cnt == LIT_LAST);
                if (slot_last) next_state = BLANK0;
            end
            BLANK0: begin
                slot_last = (cnt == BLANK_LAST);
                if (slot_last) next_state = ONES;
            end
            default: begin
                slot_last  = 1'b1;
                next_state = ONES;
            end
        endcase
    end

    // ---------------- display outputs ----------------
    logic [3:0] digit;
    logic [6:0] lit;
    logic [6:0] seg_next;
    logic [1:0] an_next;

    assign digit = (state == TENS) ? tens : q;

    bcd_to_7seg u_dec (
        .digit (digit),
        .seg   (lit)
    );

    always_comb begin
        seg_next = SEG_OFF;
        an_next  = 2'b00;
        case (state)
            ONES: begin
                seg_next = lit;
                an_next  = 2'b01;
            end
            TENS: begin
                seg_next = lit;
                an_next  = 2'b10;
            end
            default: begin
                seg_next = SEG_OFF;
                an_next  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_OFF ^ SEG_MASK;
            an  <= AN_MASK;
        end else begin
            seg <= seg_next ^ SEG_MASK;
            an  <= an_next ^ AN_MASK;
        end
    end

endmodule
